// File: rtl/memoria_dados.sv
// memoria_dados: single-port data memory for the MEM stage.
// Stores complete in one cycle and loads in two; each response is a
// one-cycle pulse with no backpressure. Words are indexed by
// req_addr[7:2], wrapping modulo DEPTH.
// Optional feature: define MEMORIA_DADOS_MISALIGN_TRAP_EN to reject
// accesses with req_addr[1:0] != 0. The memory is left untouched and
// resp_err is raised. Without it, the two low address bits are ignored.
module memoria_dados #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [7:0]  out_valor
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;

    // Contents start at zero on power-up only; rst never clears them.
    logic [31:0] mem [DEPTH] = '{default: 32'h0};

    logic [AW-1:0] word_idx;
    logic [AW-1:0] load_idx;
    logic          accept;
    logic          misaligned;
    logic          do_write;

    assign word_idx = AW'({26'd0, req_addr[7:2]} % 32'(DEPTH));
    assign accept   = req_valid && req_ready && !rst;

`ifdef MEMORIA_DADOS_MISALIGN_TRAP_EN
    assign misaligned = (req_addr[1:0] != 2'b00);
`else
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^req_addr[1:0];
    assign misaligned       = 1'b0;
`endif

    assign do_write = accept && req_we && !misaligned;

    // Store data lands on the accept edge; rst does not touch the array.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[word_idx] <= req_wdata;
        end
    end

    // Request/response sequencing with registered handshake and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            out_valor  <= 8'h0;
            load_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        if (misaligned) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else if (req_we) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= 32'h0;
                            out_valor  <= req_wdata[7:0];
                        end else begin
                            state    <= READ;
                            load_idx <= word_idx;
                        end
                    end
                end
                READ: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= mem[load_idx];
                    out_valor  <= mem[load_idx][7:0];
                end
                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memoria_dados.sv
// Testbench for memoria_dados: two instances (DEPTH=64 and DEPTH=16)
// share one request bus and are checked against an array-based model.
module tb_memoria_dados;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [7:0]  req_addr = 8'h0;
    logic [31:0] req_wdata = 32'h0;

    logic        ready64, ready16;
    logic        rv64, rv16;
    logic [31:0] rd64, rd16;
    logic        err64, err16;
    logic [7:0]  ov64, ov16;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: one word array per instance plus expected outputs.
    logic [31:0] mdl [2][64];
    logic [7:0]  exp_out [2];
    logic [31:0] exp_rd [2];
    logic        exp_err;
    int          exp_lat;

    // Observations from the last transaction.
    int          obs_lat;
    logic [31:0] obs_rd [2];
    logic        obs_err [2];
    logic [7:0]  obs_ov [2];
    logic        obs_after;

    memoria_dados #(.DEPTH(64)) dut64 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready64),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv64), .resp_rdata(rd64), .resp_err(err64), .out_valor(ov64)
    );

    memoria_dados #(.DEPTH(16)) dut16 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready16),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv16), .resp_rdata(rd16), .resp_err(err16), .out_valor(ov16)
    );

    always #5 clk = ~clk;

    // Computes the expected result of one request and updates the model memory.
    task automatic model_apply(input logic we, input logic [7:0] addr, input logic [31:0] wdata);
        logic mis;
        int   idx;
        int   depth;
`ifdef MEMORIA_DADOS_MISALIGN_TRAP_EN
        mis = (addr % 4) != 0;
`else
        mis = 1'b0;
`endif
        exp_err = mis;
        exp_lat = (mis || we) ? 1 : 2;
        for (int d = 0; d < 2; d++) begin
            depth = (d == 0) ? 64 : 16;
            idx   = (int'(addr) / 4) % depth;
            if (mis) begin
                exp_rd[d] = 32'h0;
            end else if (we) begin
                mdl[d][idx] = wdata;
                exp_rd[d]   = 32'h0;
                exp_out[d]  = wdata[7:0];
            end else begin
                exp_rd[d]  = mdl[d][idx];
                exp_out[d] = mdl[d][idx][7:0];
            end
        end
    endtask

    // Drives one request (DUT must be idle) and records what comes back.
    task automatic run_request(input logic we, input logic [7:0] addr, input logic [31:0] wdata);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        obs_lat = 1;
        while (!(rv64 && rv16) && obs_lat < 8) begin
            @(posedge clk); #1;
            obs_lat++;
        end
        obs_rd[0] = rd64;  obs_rd[1] = rd16;
        obs_err[0] = err64; obs_err[1] = err16;
        obs_ov[0] = ov64;  obs_ov[1] = ov16;
        @(posedge clk); #1;
        obs_after = rv64 | rv16 | err64 | err16 | ~ready64 | ~ready16;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({ready64, rv64, err64, rd64, ov64} !== {1'b1, 1'b0, 1'b0, 32'h0, 8'h0}) begin
            miscompares++;
            $display("[TB] FAIL reset64 got rdy=%b v=%b e=%b rd=%h ov=%h want 1 0 0 0 0", ready64, rv64, err64, rd64, ov64);
        end
        vectors++;
        if ({ready16, rv16, err16, rd16, ov16} !== {1'b1, 1'b0, 1'b0, 32'h0, 8'h0}) begin
            miscompares++;
            $display("[TB] FAIL reset16 got rdy=%b v=%b e=%b rd=%h ov=%h want 1 0 0 0 0", ready16, rv16, err16, rd16, ov16);
        end
        rst = 1'b0;
        for (int d = 0; d < 2; d++) exp_out[d] = 8'h0;
    endtask

    // Full comparison of a transaction against the model, used by each scenario.
    task automatic test_transaction(input string name, input logic we, input logic [7:0] addr, input logic [31:0] wdata);
        model_apply(we, addr, wdata);
        run_request(we, addr, wdata);
        vectors++;
        if (obs_lat !== exp_lat) begin
            miscompares++;
            $display("[TB] FAIL %s latency got %0d want %0d (addr=%h we=%b)", name, obs_lat, exp_lat, addr, we);
        end
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (obs_rd[d] !== exp_rd[d] || obs_err[d] !== exp_err || obs_ov[d] !== exp_out[d]) begin
                miscompares++;
                $display("[TB] FAIL %s dut%0d got rd=%h err=%b ov=%h want rd=%h err=%b ov=%h (addr=%h we=%b)",
                         name, d, obs_rd[d], obs_err[d], obs_ov[d], exp_rd[d], exp_err, exp_out[d], addr, we);
            end
        end
        vectors++;
        if (obs_after !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s pulse_end got busy/valid=%b want 0", name, obs_after);
        end
    endtask

    task automatic test_store_load();
        test_transaction("store_dead", 1'b1, 8'h10, 32'hDEADBEEF);
        test_transaction("load_dead", 1'b0, 8'h10, 32'h0);
        vectors++;
        if (obs_rd[0] !== 32'hDEADBEEF || obs_ov[0] !== 8'hEF || obs_lat !== 2) begin
            miscompares++;
            $display("[TB] FAIL load_dead_const got rd=%h ov=%h lat=%0d want DEADBEEF EF 2", obs_rd[0], obs_ov[0], obs_lat);
        end
    endtask

    task automatic test_unwritten();
        test_transaction("load_fc", 1'b0, 8'hFC, 32'h0);
        vectors++;
        if (obs_rd[0] !== 32'h0 || obs_err[0] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL load_fc_const got rd=%h err=%b want 0 0", obs_rd[0], obs_err[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w1, w2;
        w1 = $urandom;
        w2 = $urandom;
        model_apply(1'b1, 8'h00, w1);
        req_we = 1'b1; req_addr = 8'h00; req_wdata = w1; req_valid = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({rv64, rv16, ready64, ready16} !== 4'b1100) begin
            miscompares++;
            $display("[TB] FAIL b2b_first got v=%b%b rdy=%b%b want 11 00", rv64, rv16, ready64, ready16);
        end
        req_addr = 8'h04; req_wdata = w2;
        @(posedge clk); #1;
        vectors++;
        if ({rv64, rv16, ready64, ready16} !== 4'b0011) begin
            miscompares++;
            $display("[TB] FAIL b2b_gap got v=%b%b rdy=%b%b want 00 11", rv64, rv16, ready64, ready16);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        model_apply(1'b1, 8'h04, w2);
        vectors++;
        if ({rv64, rv16} !== 2'b11 || ov64 !== w2[7:0] || ov16 !== w2[7:0]) begin
            miscompares++;
            $display("[TB] FAIL b2b_second got v=%b%b ov=%h/%h want 11 %h", rv64, rv16, ov64, ov16, w2[7:0]);
        end
        @(posedge clk); #1;
        vectors++;
        if ({rv64, rv16, ready64, ready16} !== 4'b0011) begin
            miscompares++;
            $display("[TB] FAIL b2b_end got v=%b%b rdy=%b%b want 00 11", rv64, rv16, ready64, ready16);
        end
        test_transaction("b2b_load0", 1'b0, 8'h00, 32'h0);
        test_transaction("b2b_load4", 1'b0, 8'h04, 32'h0);
    endtask

    task automatic test_misalign();
        test_transaction("store_05", 1'b1, 8'h05, 32'hA5A5_1234);
        test_transaction("load_word1", 1'b0, 8'h04, 32'h0);
        test_transaction("load_07", 1'b0, 8'h07, 32'h0);
    endtask

    task automatic test_depth16();
        test_transaction("store_40", 1'b1, 8'h40, 32'h11111111);
        test_transaction("load_00", 1'b0, 8'h00, 32'h0);
        vectors++;
        if (obs_rd[1] !== 32'h11111111) begin
            miscompares++;
            $display("[TB] FAIL wrap16 got %h want 11111111", obs_rd[1]);
        end
    endtask

    task automatic test_reset_mid_load();
        model_apply(1'b0, 8'h10, 32'h0);
        req_we = 1'b0; req_addr = 8'h10; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) exp_out[d] = 8'h0;
        vectors++;
        if ({rv64, rv16, err64, err16, ready64, ready16, rd64, rd16, ov64, ov16} !==
            {6'b000011, 32'h0, 32'h0, 8'h0, 8'h0}) begin
            miscompares++;
            $display("[TB] FAIL rst_load got v=%b%b e=%b%b rdy=%b%b rd=%h/%h ov=%h/%h want all 0, rdy 11",
                     rv64, rv16, err64, err16, ready64, ready16, rd64, rd16, ov64, ov16);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            vectors++;
            if ({rv64, rv16, ready64, ready16} !== 4'b0011) begin
                miscompares++;
                $display("[TB] FAIL rst_load_after%0d got v=%b%b rdy=%b%b want 00 11", c, rv64, rv16, ready64, ready16);
            end
        end
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] w;
        w = $urandom;
        model_apply(1'b1, 8'h20, w);
        req_we = 1'b1; req_addr = 8'h20; req_wdata = w; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) exp_out[d] = 8'h0;
        vectors++;
        if ({rv64, rv16, ov64, ov16} !== {2'b00, 16'h0}) begin
            miscompares++;
            $display("[TB] FAIL rst_store got v=%b%b ov=%h/%h want 00 0", rv64, rv16, ov64, ov16);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        test_transaction("rst_store_kept", 1'b0, 8'h20, 32'h0);
    endtask

    task automatic test_random();
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        for (int i = 0; i < 60; i++) begin
            we    = 1'($urandom_range(0, 1));
            addr  = 8'($urandom_range(0, 255));
            wdata = $urandom;
            test_transaction("random", we, addr, wdata);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 64; i++) mdl[d][i] = 32'h0;
            exp_out[d] = 8'h0;
        end
        test_reset();
        test_store_load();
        test_unwritten();
        test_back_to_back();
        test_misalign();
        test_depth16();
        test_reset_mid_load();
        test_reset_mid_store();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
